delta_calc: RTL and testbench
=============================

DELTA_CALC -- requirements
Module: delta_calc

Interface
REQ-001 Parameter WIDTH, default 32: data word width, signed fixed point.
REQ-002 Parameter FRAC, default 24: fractional bits (Q8.24 at default; 1.0 = 32'h01000000).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_act  input  WIDTH  neuron activation a (sigmoid output), signed.
REQ-006 i_tgt  input  WIDTH  training target t, signed.
REQ-007 i_valid  input  1  upstream offers i_act/i_tgt.
REQ-008 o_ready  output  1  block can accept an operand pair.
REQ-009 o_delta  output  WIDTH  output-layer delta = (a - t) * a * (1 - a), signed.
REQ-010 o_valid  output  1  o_delta holds a valid result.
REQ-011 i_ready  input  1  downstream accepts o_delta.

Function
REQ-012 FSM states SHALL be IDLE, DERIV, DELTA, DONE; one shared WIDTH x WIDTH multiplier.
REQ-013 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-014 IDLE with i_valid=1: capture a, t; error = a - t (WIDTH bits); go to DERIV. IDLE with i_valid=0: stay.
REQ-015 DERIV: deriv = (a * (1.0 - a)) >>> FRAC, registered; go to DELTA.
REQ-016 DELTA: o_delta = (error * deriv) >>> FRAC, registered; go to DONE.
REQ-017 Products SHALL be formed at 2*WIDTH, arithmetic right shift (floor), result narrowed to WIDTH per REQ-024/025.
REQ-018 DONE: hold o_delta and o_valid stable while i_ready=0; on i_ready=1 go to IDLE.
REQ-019 Latency: o_valid rises on the 3rd rising edge after the accepting edge; at most one result per 4 cycles.
REQ-020 i_valid/operands SHALL be ignored outside IDLE; i_ready SHALL be ignored outside DONE.
REQ-021 o_delta SHALL change only on the DELTA->DONE transition and at reset.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, o_valid=0, o_delta=0, internal registers 0, o_ready=1 combinationally from state.
REQ-023 Reset mid-operation SHALL discard the in-flight pair; no o_valid pulse for it.

Configuration
REQ-024 With macro DELTA_CALC_SAT_EN defined, error, deriv and o_delta SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] on overflow.
REQ-025 Without DELTA_CALC_SAT_EN, all three SHALL wrap (keep low WIDTH bits) and no saturation logic is present.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the Q-format constant ONE = 1 << FRAC, and the saturating/wrapping narrowing function.
REQ-027 The single sub-module SHALL be mult_2in (WIDTH, FRAC), time-shared between DERIV and DELTA via operand muxes.

Verification
REQ-028 a=32'h00800000, t=0 -> o_delta=32'h00200000 (0.125), o_valid on 3rd edge after accept.
REQ-029 a=32'h00C00000, t=32'h01000000 -> o_delta=32'hFFF40000 (-0.046875).
REQ-030 a=32'h08000000, t=0 -> o_delta=32'h80000000 with DELTA_CALC_SAT_EN, 32'h40000000 without.
REQ-031 i_ready=0 for 5 cycles in DONE -> o_delta/o_valid stable, o_ready=0, new i_valid ignored; i_ready=1 -> IDLE next cycle.
REQ-032 rst pulse during DELTA -> o_valid=0, o_delta=0, o_ready=1 at once; next pair processed with correct result.
REQ-033 Back-to-back i_valid=1 with i_ready=1 -> results in order, one per 4 cycles, no pair dropped or duplicated.

Source files
------------

// File: rtl/delta_calc_pkg.sv
// Shared FSM states, Q-format unit constant and result narrowing for delta_calc.
// Narrowing saturates when DELTA_CALC_SAT_EN is defined and wraps to the low bits otherwise.
package delta_calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DERIV = 2'd1,
        DELTA = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int     FRAC_DEF = 24;
    localparam longint ONE      = 64'sd1 <<< FRAC_DEF;

    // 1.0 in Q(.frac) for an arbitrary fraction width
    function automatic longint q_one(input int frac);
        return 64'sd1 <<< frac;
    endfunction

    // Fits x into a signed w-bit word; the result is sign-extended to 64 bits
    function automatic logic signed [63:0] narrow(input logic signed [127:0] x, input int w);
        logic signed [127:0] lo;
`ifdef DELTA_CALC_SAT_EN
        logic signed [127:0] max_v;
        logic signed [127:0] min_v;
        max_v = (128'sd1 <<< (w - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (w - 1));
        if (x > max_v)
            lo = max_v;
        else if (x < min_v)
            lo = min_v;
        else
            lo = x;
`else
        lo = (x <<< (128 - w)) >>> (128 - w);
`endif
        return 64'(lo);
    endfunction

endpackage

// File: rtl/delta_calc_mult.sv
// Combinational signed WIDTH x WIDTH multiply at 2*WIDTH, rescaled by an arithmetic shift of FRAC.
// Zero latency, no flow control; the caller registers the product.
module mult_2in #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0]   op_a,
    input  logic signed [WIDTH-1:0]   op_b,
    output logic signed [2*WIDTH-1:0] prod
);

    logic signed [2*WIDTH-1:0] full;

    assign full = op_a * op_b;
    assign prod = full >>> FRAC;

endmodule

// File: rtl/delta_calc.sv
// Output-layer delta (a - t) * a * (1 - a); result valid three edges after accept, one pair per 4 cycles.
// Valid/ready both sides: accepts only in IDLE, holds the result in DONE until downstream takes it (DELTA_CALC_SAT_EN saturates).
module delta_calc
    import delta_calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] i_act,
    input  logic signed [WIDTH-1:0] i_tgt,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic signed [WIDTH-1:0] o_delta,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam logic signed [WIDTH-1:0] ONE_Q = WIDTH'(q_one(FRAC));

    state_t state;
    state_t state_nx;

    logic signed [WIDTH-1:0]   a_q;
    logic signed [WIDTH-1:0]   err_q;
    logic signed [WIDTH-1:0]   deriv_q;
    logic signed [WIDTH:0]     diff;
    logic signed [WIDTH-1:0]   err_n;
    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   res_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = DERIV;
            DERIV:   state_nx = DELTA;
            DELTA:   state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    // One extra bit so the subtraction itself never overflows before narrowing
    assign diff  = {i_act[WIDTH-1], i_act} - {i_tgt[WIDTH-1], i_tgt};
    assign err_n = WIDTH'(narrow(128'(diff), WIDTH));

    // DELTA multiplies error by derivative; every other state presents a and (1 - a)
    assign op_a = (state == DELTA) ? err_q   : a_q;
    assign op_b = (state == DELTA) ? deriv_q : ONE_Q - a_q;

    mult_2in #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .op_a (op_a),
        .op_b (op_b),
        .prod (prod)
    );

    assign res_n = WIDTH'(narrow(128'(prod), WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            err_q   <= '0;
            deriv_q <= '0;
            o_delta <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q   <= i_act;
                        err_q <= err_n;
                    end
                end
                DERIV:   deriv_q <= res_n;
                DELTA:   o_delta <= res_n;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delta_calc.sv
// Randomized self-checking bench for delta_calc against an arithmetic reference model.
module tb_delta_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_act;
    logic [31:0] i_tgt;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_delta;
    logic        o_valid;
    logic        i_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] prev_delta;

    delta_calc #(.WIDTH(32), .FRAC(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_act   (i_act),
        .i_tgt   (i_tgt),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_delta (o_delta),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on real-valued Q8.24 numbers
    function automatic logic [31:0] fit(input longint v);
`ifdef DELTA_CALC_SAT_EN
        if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] t);
        longint av, tv, err, der, one;
        one = 64'sd1 <<< 24;
        av  = longint'(signed'(a));
        tv  = longint'(signed'(t));
        err = longint'(signed'(fit(av - tv)));
        der = longint'(signed'(fit((av * (one - av)) >>> 24)));
        return fit((err * der) >>> 24);
    endfunction

    task automatic do_pair(input logic [31:0] a, input logic [31:0] t,
                           input logic [31:0] exp, input int stall);
        int edges;
        @(negedge clk);
        check("ready_idle", 32'(o_ready), 32'd1);
        i_act   = a;
        i_tgt   = t;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        edges = 1;
        while (!o_valid && edges < 8) begin
            check("delta_held", o_delta, prev_delta);
            i_valid = 1'($urandom_range(0, 1));
            i_act   = $urandom;
            i_tgt   = $urandom;
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 32'(edges), 32'd3);
        check("delta", o_delta, exp);
        for (int k = 0; k < stall; k++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_act   = $urandom;
            @(posedge clk); #1;
            check("stall_delta", o_delta, exp);
            check("stall_vld_rdy", {30'd0, o_valid, o_ready}, 32'd2);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("back_to_idle", {30'd0, o_valid, o_ready}, 32'd1);
        prev_delta = exp;
    endtask

    initial begin
        logic [31:0] a, t;
        logic [31:0] expq[$];
        int          acc, got, last_cyc;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_act   = '0;
        i_tgt   = '0;
        prev_delta = '0;
        #12;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_delta", o_delta, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_pair(32'h00800000, 32'h00000000, 32'h00200000, 0);
        do_pair(32'h00C00000, 32'h01000000, 32'hFFF40000, 0);
`ifdef DELTA_CALC_SAT_EN
        do_pair(32'h08000000, 32'h00000000, 32'h80000000, 0);
`else
        do_pair(32'h08000000, 32'h00000000, 32'h40000000, 0);
`endif
        do_pair(32'h00600000, 32'h01000000, model(32'h00600000, 32'h01000000), 5);

        for (int n = 0; n < 16; n++) begin
            if (n % 2 == 0) begin
                a = 32'($urandom_range(0, 32'h01000000));
                t = (n % 4 == 0) ? 32'h01000000 : 32'h00000000;
            end else begin
                a = 32'(signed'($urandom) >>> 1);
                t = 32'(signed'($urandom) >>> 1);
            end
            do_pair(a, t, model(a, t), $urandom_range(0, 3));
        end

        // Reset while the pair is in DELTA
        do_pair(32'h00400000, 32'h00000000, model(32'h00400000, 32'h00000000), 0);
        @(negedge clk);
        i_act   = 32'h00800000;
        i_tgt   = 32'h00000000;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_delta", o_delta, 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        prev_delta = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("no_pulse", 32'(o_valid), 32'd0);
        end
        do_pair(32'h00C00000, 32'h00000000, model(32'h00C00000, 32'h00000000), 1);

        // Streaming: source always valid, sink always ready
        acc = 0;
        got = 0;
        last_cyc = -1;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc < 40) begin
                i_valid = 1'b1;
                i_act   = 32'($urandom_range(0, 32'h01000000));
                i_tgt   = 32'($urandom_range(0, 32'h01000000));
            end else begin
                i_valid = 1'b0;
            end
            if (o_ready && i_valid) begin
                expq.push_back(model(i_act, i_tgt));
                acc++;
            end
            if (o_valid) begin
                if (expq.size() == 0) begin
                    check("b2b_extra", 32'd1, 32'd0);
                end else begin
                    check("b2b_delta", o_delta, expq.pop_front());
                end
                if (last_cyc >= 0)
                    check("b2b_spacing", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                got++;
            end
        end
        check("b2b_drain", 32'(expq.size()), 32'd0);
        check("b2b_count", 32'(got), 32'(acc));
        check("b2b_nonempty", 32'(acc > 5), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
